issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- Parametrised successor of the single-scoreboard issue stage. Sits between decode and execute.
- Tracks a pending-write bit per architectural register and a countdown timer per functional unit (FU).
- Stalls fetch/decode on RAW hazards, WAW hazards, structural hazards (FU busy) and execute back-pressure.
- Clears pending bits automatically when the owning FU's fixed latency expires.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hard-wired zero and never pending.
- NUM_FU, 4, number of functional units; FU index = tag.
- LAT_W, 4, width of each FU latency field and countdown counter.
- LAT_VEC, 16'h8431, packed per-FU latency, FU0 in the LSBs: FU0=1 (ALU), FU1=3 (MEM), FU2=4 (MUL), FU3=8 (DIV). Each field is 1..2^LAT_W-1; 0 is illegal.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  decode presents an instruction.
- id_numop  in  2  source operand count (0, 1 = addra only, 2 = addra and addrb).
- id_addra  in  clog2(NUM_REGS)  source A.
- id_addrb  in  clog2(NUM_REGS)  source B.
- id_regdest  in  clog2(NUM_REGS)  destination register.
- id_writereg  in  1  instruction writes id_regdest.
- id_fu  in  clog2(NUM_FU)  target FU chosen by decode.
- execute_stall  in  1  execute cannot accept this cycle.
- is_if_stall  out  1  hold fetch/decode.
- is_ex_issue  out  1  instruction issues at this edge.
- is_ex_fu  out  clog2(NUM_FU)  FU of the issued instruction; 0 when not issuing.
- fu_busy  out  NUM_FU  per-FU counter != 0.
- fu_done  out  NUM_FU  per-FU counter == 1 (completes at this edge).
- pnd_sgn  out  NUM_REGS  pending-write bits.

Behaviour:
- Reset (synchronous, active-high): all pending bits, counters and FU destination registers go to 0. Every output is 0 in the cycle after the reset edge. Reset asserted mid-operation aborts all in-flight FUs; no fu_done pulse is produced.
- Hazard terms (combinational, current state only):
  - raw_a = numop>=1 & pnd[addra]
  - raw_b = numop==2 & pnd[addrb]
  - waw = writereg & pnd[regdest]
  - struct = fu_busy[id_fu] | (id_fu >= NUM_FU)
- stall = id_valid & (raw_a | raw_b | waw | struct | execute_stall). is_if_stall = stall.
- is_ex_issue = id_valid & !stall. Both are combinational.
- No same-cycle bypass: a register cleared at edge E is seen as free only in the cycle after E.
- Issue at edge E:
  - cnt[id_fu] <= LAT(id_fu); fu_dest[id_fu] <= regdest; fu_wr[id_fu] <= writereg & (regdest != 0).
  - If writereg & regdest != 0, pnd[regdest] <= 1.
- Countdown: every edge, any cnt != 0 decrements, independent of execute_stall.
  - When cnt == 1 (fu_done high), at that edge cnt becomes 0 and, if fu_wr, pnd[fu_dest] is cleared.
- Resulting latency:
  - FU is busy for exactly LAT cycles after its issue edge.
  - A dependent instruction presented right after the producer issues at edge E+LAT+1, after LAT stall cycles.
  - A new instruction to the same FU issues no earlier than edge E+LAT+1. FUs are non-pipelined.
- Simultaneous events:
  - A set and a clear of the same register at one edge cannot occur legally, because WAW stalls. If it does occur, set wins.
  - Clears from several FUs at one edge are OR-combined.
  - Issue into an FU whose fu_done is high is stalled, because busy is still 1.
- Register 0 pnd bit is constant 0. Writes to r0 never set pending.
- id_valid=0: no stall and no issue; counters keep running.

Decomposition:
- Package issue_pkg:
  - localparams REG_AW = clog2(NUM_REGS) and FU_AW = clog2(NUM_FU).
  - A function lat_of(fu) that extracts a field from LAT_VEC.
  - FU tag constants FU_ALU=0, FU_MEM=1, FU_MUL=2, FU_DIV=3.
- Sub-module fu_timer, instantiated NUM_FU times:
  - Holds the LAT_W countdown, dest and wr flag.
  - Outputs busy, done, dest and wr.
  - The top level owns the pending vector and hazard logic.

Test Plan:
1. RAW: issue MEM (FU1) writing r5 at edge E. Next, ADD (FU0, numop=1, addra=5) -> is_if_stall=1 for 3 cycles; pnd_sgn[5] falls at E+3; ADD issues at E+4 with is_ex_fu=0.
2. WAW plus structural: DIV (FU3) writes r7 at E. MUL (FU2) writing r7 stalls until pnd_sgn[7]=0 at E+8. A second DIV writing r9 also stalls (fu_busy[3]=1) until E+9.
3. Independent overlap: MUL r3 at E, ADD r4 at E+1, no stall. fu_done[0] at the cycle before E+2; fu_done[2] at the cycle before E+4; both pending bits clear at the correct edges.
4. execute_stall=1 for 2 cycles with an independent ADD -> no issue during the stall; FU counters still decrement; ADD issues on the first cycle execute_stall=0.
5. r0 and numop: ADD writing r0 -> pnd_sgn stays 0. A numop=0 instruction reading a pending addra -> no stall.
6. Reset mid-flight: DIV issued, reset at E+2 -> all outputs 0 the next cycle; a dependent instruction issues immediately after reset deasserts.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared constants for the issue scoreboard: default geometry, FU tags and
// the helper that pulls one latency field out of a packed latency vector.
package issue_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int NUM_FU_DEF   = 4;
  localparam int LAT_W_DEF    = 4;
  localparam logic [15:0] LAT_VEC_DEF = 16'h8431;

  localparam int REG_AW = $clog2(NUM_REGS_DEF);
  localparam int FU_AW  = $clog2(NUM_FU_DEF);

  localparam int FU_ALU = 0;
  localparam int FU_MEM = 1;
  localparam int FU_MUL = 2;
  localparam int FU_DIV = 3;

  // Field fu of width w, FU0 in the LSBs; callers truncate to their own width.
  function automatic logic [15:0] lat_of(input logic [63:0] vec, input int w, input int fu);
    logic [63:0] sh;
    sh = vec >> (fu * w);
    lat_of = sh[15:0] & 16'((1 << w) - 1);
  endfunction

endpackage

// File: rtl/fu_timer.sv
// Per-FU countdown: loaded with the fixed latency on issue, counts to zero,
// and remembers which register (if any) the in-flight op will write.
module fu_timer
  import issue_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF,
  parameter int AW    = REG_AW,
  parameter logic [LAT_W-1:0] LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] dest_in,
  input  logic          wr_in,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] dest,
  output logic          wr
);

  logic [LAT_W-1:0] cnt;

  // start only arrives when the FU is idle, so it never races the countdown
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= '0;
      dest <= '0;
      wr   <= 1'b0;
    end else if (start) begin
      cnt  <= LAT;
      dest <= dest_in;
      wr   <= wr_in;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);
  assign done = (cnt == LAT_W'(1));

endmodule

// File: rtl/issue_scoreboard.sv
// Issue stage: pending-write bit per register plus one timer per FU; stalls
// decode on RAW, WAW, busy FU or execute back-pressure.
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_FU   = NUM_FU_DEF,
  parameter int LAT_W    = LAT_W_DEF,
  parameter logic [NUM_FU*LAT_W-1:0] LAT_VEC = LAT_VEC_DEF,
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int TW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [1:0]          id_numop,
  input  logic [AW-1:0]       id_addra,
  input  logic [AW-1:0]       id_addrb,
  input  logic [AW-1:0]       id_regdest,
  input  logic                id_writereg,
  input  logic [TW-1:0]       id_fu,
  input  logic                execute_stall,
  output logic                is_if_stall,
  output logic                is_ex_issue,
  output logic [TW-1:0]       is_ex_fu,
  output logic [NUM_FU-1:0]   fu_busy,
  output logic [NUM_FU-1:0]   fu_done,
  output logic [NUM_REGS-1:0] pnd_sgn
);

  logic [NUM_REGS-1:0] pnd, set_v, clr_v;
  logic [NUM_FU-1:0]   start_v, wr_v;
  logic [AW-1:0]       dest_v [NUM_FU];
  logic [2**TW-1:0]    busy_ext;
  logic raw_a, raw_b, waw, struct_h, stall, wr_eff;

  assign busy_ext = (2**TW)'(fu_busy);
  assign raw_a    = (id_numop != 2'd0) & pnd[id_addra];
  assign raw_b    = (id_numop == 2'd2) & pnd[id_addrb];
  assign waw      = id_writereg & pnd[id_regdest];
  assign struct_h = busy_ext[id_fu] | ({1'b0, id_fu} >= (TW+1)'(NUM_FU));
  assign wr_eff   = id_writereg & (id_regdest != '0);

  // Handshake: decode holds id_* while is_if_stall is high; an instruction is
  // consumed at the clock edge ending a cycle with id_valid=1 and is_ex_issue=1.
  assign stall       = id_valid & (raw_a | raw_b | waw | struct_h | execute_stall);
  assign is_if_stall = stall;
  assign is_ex_issue = id_valid & ~stall;
  assign is_ex_fu    = is_ex_issue ? id_fu : '0;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    assign start_v[i] = is_ex_issue & (id_fu == TW'(i));
    fu_timer #(
      .LAT_W (LAT_W),
      .AW    (AW),
      .LAT   (LAT_W'(lat_of(64'(LAT_VEC), LAT_W, i)))
    ) u_timer (
      .clock   (clock),
      .reset   (reset),
      .start   (start_v[i]),
      .dest_in (id_regdest),
      .wr_in   (wr_eff),
      .busy    (fu_busy[i]),
      .done    (fu_done[i]),
      .dest    (dest_v[i]),
      .wr      (wr_v[i])
    );
  end

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (is_ex_issue & wr_eff) set_v[id_regdest] = 1'b1;
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_done[i] & wr_v[i]) clr_v[dest_v[i]] = 1'b1;
    end
  end

  // Set is applied after clear so a same-edge collision leaves the bit pending.
  always_ff @(posedge clock) begin
    if (reset) pnd <= '0;
    else       pnd <= ((pnd & ~clr_v) | set_v) & ~NUM_REGS'(1);
  end

  assign pnd_sgn = pnd;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: hazards, overlap, back-pressure,
// r0 / numop handling and mid-flight reset, with hand-computed expectations.
module tb_issue_scoreboard;
  import issue_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [1:0]  id_numop;
  logic [4:0]  id_addra, id_addrb, id_regdest;
  logic        id_writereg;
  logic [1:0]  id_fu;
  logic        execute_stall;
  logic        is_if_stall, is_ex_issue;
  logic [1:0]  is_ex_fu;
  logic [3:0]  fu_busy, fu_done;
  logic [31:0] pnd_sgn;

  int tests = 0;
  int fails = 0;

  issue_scoreboard dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_numop(id_numop),
    .id_addra(id_addra), .id_addrb(id_addrb), .id_regdest(id_regdest),
    .id_writereg(id_writereg), .id_fu(id_fu), .execute_stall(execute_stall),
    .is_if_stall(is_if_stall), .is_ex_issue(is_ex_issue), .is_ex_fu(is_ex_fu),
    .fu_busy(fu_busy), .fu_done(fu_done), .pnd_sgn(pnd_sgn)
  );

  // clock/reset block
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_numop = 2'd0; id_addra = '0; id_addrb = '0;
    id_regdest = '0; id_writereg = 1'b0; id_fu = '0;
    #1;
  endtask

  task automatic present(input int fu, input int rd, input bit wr,
                         input int numop, input int a, input int b);
    id_valid = 1'b1; id_fu = 2'(fu); id_regdest = 5'(rd); id_writereg = wr;
    id_numop = 2'(numop); id_addra = 5'(a); id_addrb = 5'(b);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; execute_stall = 1'b0;
    idle();
    tick(); tick();
    chk("rst_stall", 32'(is_if_stall), 32'd0);
    chk("rst_issue", 32'(is_ex_issue), 32'd0);
    chk("rst_exfu",  32'(is_ex_fu), 32'd0);
    chk("rst_busy",  32'(fu_busy), 32'd0);
    chk("rst_done",  32'(fu_done), 32'd0);
    chk("rst_pnd",   pnd_sgn, 32'd0);
    reset = 1'b0;
    tick();

    // 1: RAW on MEM result r5
    present(FU_MEM, 5, 1, 0, 0, 0);
    chk("t1_mem_issue", 32'(is_ex_issue), 32'd1);
    chk("t1_mem_fu", 32'(is_ex_fu), 32'd1);
    tick();
    present(FU_ALU, 6, 1, 1, 5, 0);
    chk("t1_stall0", 32'(is_if_stall), 32'd1);
    chk("t1_pnd5_set", 32'(pnd_sgn[5]), 32'd1);
    chk("t1_busy", 32'(fu_busy), 32'b0010);
    tick();
    chk("t1_stall1", 32'(is_if_stall), 32'd1);
    tick();
    chk("t1_stall2", 32'(is_if_stall), 32'd1);
    chk("t1_done_mem", 32'(fu_done), 32'b0010);
    tick();
    chk("t1_nostall", 32'(is_if_stall), 32'd0);
    chk("t1_add_issue", 32'(is_ex_issue), 32'd1);
    chk("t1_add_fu", 32'(is_ex_fu), 32'd0);
    chk("t1_pnd5_clr", 32'(pnd_sgn[5]), 32'd0);
    tick();
    idle();
    chk("t1_pnd6", 32'(pnd_sgn[6]), 32'd1);
    chk("t1_done_alu", 32'(fu_done), 32'b0001);
    tick();
    chk("t1_drain", pnd_sgn, 32'd0);
    chk("t1_idle_busy", 32'(fu_busy), 32'd0);

    // 2a: WAW on DIV result r7
    present(FU_DIV, 7, 1, 0, 0, 0);
    chk("t2_div_issue", 32'(is_ex_issue), 32'd1);
    tick();
    present(FU_MUL, 7, 1, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      chk("t2_waw_stall", 32'(is_if_stall), 32'd1);
      tick();
    end
    chk("t2_waw_stall7", 32'(is_if_stall), 32'd1);
    chk("t2_div_done", 32'(fu_done), 32'b1000);
    tick();
    chk("t2_mul_issue", 32'(is_ex_issue), 32'd1);
    chk("t2_mul_fu", 32'(is_ex_fu), 32'd2);
    chk("t2_pnd7_clr", 32'(pnd_sgn[7]), 32'd0);
    tick();
    idle();
    chk("t2_mul_busy", 32'(fu_busy), 32'b0100);
    chk("t2_pnd7_again", 32'(pnd_sgn[7]), 32'd1);
    for (int k = 0; k < 5; k++) tick();
    chk("t2a_drain", pnd_sgn, 32'd0);

    // 2b: structural hazard, second DIV
    present(FU_DIV, 8, 1, 0, 0, 0);
    chk("t2b_div1_issue", 32'(is_ex_issue), 32'd1);
    tick();
    present(FU_DIV, 9, 1, 0, 0, 0);
    chk("t2b_pnd9_free", 32'(pnd_sgn[9]), 32'd0);
    for (int k = 0; k < 7; k++) begin
      chk("t2b_struct_stall", 32'(is_if_stall), 32'd1);
      tick();
    end
    chk("t2b_stall_on_done", 32'(is_if_stall), 32'd1);
    chk("t2b_done", 32'(fu_done), 32'b1000);
    tick();
    chk("t2b_div2_issue", 32'(is_ex_issue), 32'd1);
    chk("t2b_div2_fu", 32'(is_ex_fu), 32'd3);
    tick();
    idle();
    chk("t2b_busy", 32'(fu_busy), 32'b1000);
    chk("t2b_pnd9", 32'(pnd_sgn[9]), 32'd1);
    for (int k = 0; k < 9; k++) tick();
    chk("t2b_drain", pnd_sgn, 32'd0);

    // 3: independent overlap MUL r3 then ADD r4
    present(FU_MUL, 3, 1, 0, 0, 0);
    chk("t3_mul_issue", 32'(is_ex_issue), 32'd1);
    tick();
    present(FU_ALU, 4, 1, 2, 1, 2);
    chk("t3_add_nostall", 32'(is_if_stall), 32'd0);
    chk("t3_add_issue", 32'(is_ex_issue), 32'd1);
    tick();
    idle();
    chk("t3_done_alu", 32'(fu_done), 32'b0001);
    chk("t3_pnd_both", pnd_sgn, 32'h0000_0018);
    tick();
    chk("t3_pnd4_clr", pnd_sgn, 32'h0000_0008);
    chk("t3_done_none", 32'(fu_done), 32'd0);
    tick();
    chk("t3_done_mul", 32'(fu_done), 32'b0100);
    tick();
    chk("t3_pnd3_clr", pnd_sgn, 32'd0);
    chk("t3_busy", 32'(fu_busy), 32'd0);

    // 4: execute back-pressure while MUL counts down
    present(FU_MUL, 10, 1, 0, 0, 0);
    tick();
    present(FU_ALU, 11, 1, 0, 0, 0);
    execute_stall = 1'b1;
    #1;
    chk("t4_bp_stall", 32'(is_if_stall), 32'd1);
    chk("t4_bp_noissue0", 32'(is_ex_issue), 32'd0);
    tick();
    chk("t4_bp_noissue1", 32'(is_ex_issue), 32'd0);
    chk("t4_bp_busy", 32'(fu_busy), 32'b0100);
    tick();
    execute_stall = 1'b0;
    #1;
    chk("t4_issue", 32'(is_ex_issue), 32'd1);
    tick();
    idle();
    chk("t4_done_both", 32'(fu_done), 32'b0101);
    tick();
    chk("t4_drain", pnd_sgn, 32'd0);

    // 5: r0 never pending, numop gates source checks
    present(FU_ALU, 0, 1, 0, 0, 0);
    chk("t5_r0_issue", 32'(is_ex_issue), 32'd1);
    tick();
    idle();
    chk("t5_r0_pnd", pnd_sgn, 32'd0);
    chk("t5_r0_busy", 32'(fu_busy), 32'b0001);
    tick();
    present(FU_MUL, 12, 1, 0, 0, 0);
    tick();
    present(FU_ALU, 1, 0, 1, 12, 0);
    chk("t5_numop1_stall", 32'(is_if_stall), 32'd1);
    present(FU_ALU, 1, 0, 0, 12, 0);
    chk("t5_numop0_nostall", 32'(is_if_stall), 32'd0);
    chk("t5_numop0_issue", 32'(is_ex_issue), 32'd1);
    tick();
    idle();
    for (int k = 0; k < 4; k++) tick();
    chk("t5_drain", pnd_sgn, 32'd0);

    // 6: reset mid-flight aborts DIV r13
    present(FU_DIV, 13, 1, 0, 0, 0);
    tick();
    idle();
    tick();
    reset = 1'b1;
    chk("t6_pre_busy", 32'(fu_busy), 32'b1000);
    tick();
    reset = 1'b0;
    chk("t6_busy", 32'(fu_busy), 32'd0);
    chk("t6_done", 32'(fu_done), 32'd0);
    chk("t6_pnd", pnd_sgn, 32'd0);
    chk("t6_stall", 32'(is_if_stall), 32'd0);
    chk("t6_issue0", 32'(is_ex_issue), 32'd0);
    present(FU_ALU, 14, 1, 1, 13, 0);
    chk("t6_dep_issue", 32'(is_ex_issue), 32'd1);
    tick();
    idle();
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t6_no_div_done", 32'(fu_done[3]), 32'd0);
    end
    chk("t6_drain", pnd_sgn, 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
